// File: rtl/rv32_imem_loader_pkg.sv
// Shared types for the instruction-memory program loader: address/instruction
// word types, loader FSM states and error codes.
package rv32_imem_loader_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int INSTR_W     = 32;

  typedef logic [IMEM_ADDR_W-1:0] rv32_imem_addr_t;
  typedef logic [INSTR_W-1:0]     rv32_instr_t;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_HDR     = 3'd1,
    LD_DATA    = 3'd2,
    LD_WRITE   = 3'd3,
    LD_RELEASE = 3'd4,
    LD_DONE    = 3'd5,
    LD_ERR     = 3'd6
  } ld_state_t;

  typedef enum logic [1:0] {
    LD_ERR_NONE    = 2'd0,
    LD_ERR_COUNT   = 2'd1,
    LD_ERR_TIMEOUT = 2'd2
  } ld_err_t;

  // A header word count is usable when it is non-zero and fits in the imem.
  function automatic logic count_ok(input logic [31:0] count, input int depth);
    return (count != 32'd0) && (count <= 32'(depth));
  endfunction

endpackage

// File: rtl/rv32_imem_loader_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words. The completed word and
// its one-cycle valid flag are presented combinationally on the edge that
// accepts the fourth byte, so the caller can register it without extra delay.
module rv32_imem_loader_byte_assembler
  import rv32_imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_fire,
  output rv32_instr_t word,
  output logic        word_valid
);

  logic [1:0]  idx_r;
  logic [23:0] shift_r;

  // Byte lane index and the three lower bytes collected so far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (clr) begin
      idx_r   <= 2'd0;
      shift_r <= shift_r;
    end else if (byte_fire) begin
      idx_r   <= idx_r + 2'd1;
      shift_r <= {byte_in, shift_r[23:8]};
    end else begin
      idx_r   <= idx_r;
      shift_r <= shift_r;
    end
  end

  assign word       = {byte_in, shift_r};
  assign word_valid = byte_fire && (idx_r == 2'd3);

endmodule

// File: rtl/rv32_imem_loader.sv
// Program loader: receives a 4-byte word count followed by that many
// little-endian instruction words, writes them to consecutive imem addresses
// while holding the core in reset/program mode, then releases the core.
module rv32_imem_loader
  import rv32_imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH     = 1024,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int RELEASE_DELAY  = 2
) (
  input  logic                   rv32_io_clk,
  input  logic                   rv32_io_rst_n,
  input  logic                   ld_start,
  input  logic [7:0]             ld_byte,
  input  logic                   ld_byte_valid,
  output logic                   ld_byte_ready,
  output logic                   rv32_io_imem_w_en,
  output logic [IMEM_ADDR_W-1:0] rv32_io_imem_addr,
  output logic [INSTR_W-1:0]     rv32_io_imem_data,
  output logic                   rv32_io_program,
  output logic                   core_rst_n,
  output logic                   ld_busy,
  output logic                   ld_done,
  output logic [1:0]             ld_err,
  output logic [31:0]            ld_words
);

  ld_state_t       state_r, state_n;
  logic [31:0]     count_r, count_n;
  logic [31:0]     words_r, words_n;
  logic [31:0]     tmo_r, tmo_n;
  logic [31:0]     rel_r, rel_n;
  logic            ready_r, ready_n;
  logic            w_en_r, w_en_n;
  rv32_imem_addr_t addr_r, addr_n;
  rv32_instr_t     data_r, data_n;
  logic            program_r, program_n;
  logic            core_rst_n_r, core_rst_n_n;
  logic            busy_r, busy_n;
  logic            done_r, done_n;
  ld_err_t         err_r, err_n;

  logic            fire_s;
  logic            asm_clr_s;
  rv32_instr_t     word_s;
  logic            word_valid_s;

  assign fire_s = ld_byte_valid && ready_r;

  rv32_imem_loader_byte_assembler u_asm (
    .clk        (rv32_io_clk),
    .rst_n      (rv32_io_rst_n),
    .clr        (asm_clr_s),
    .byte_in    (ld_byte),
    .byte_fire  (fire_s),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
    if (!rv32_io_rst_n) begin
      state_r      <= LD_IDLE;
      count_r      <= 32'd0;
      words_r      <= 32'd0;
      tmo_r        <= 32'd0;
      rel_r        <= 32'd0;
      ready_r      <= 1'b0;
      w_en_r       <= 1'b0;
      addr_r       <= '0;
      data_r       <= '0;
      program_r    <= 1'b0;
      core_rst_n_r <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= LD_ERR_NONE;
    end else begin
      state_r      <= state_n;
      count_r      <= count_n;
      words_r      <= words_n;
      tmo_r        <= tmo_n;
      rel_r        <= rel_n;
      ready_r      <= ready_n;
      w_en_r       <= w_en_n;
      addr_r       <= addr_n;
      data_r       <= data_n;
      program_r    <= program_n;
      core_rst_n_r <= core_rst_n_n;
      busy_r       <= busy_n;
      done_r       <= done_n;
      err_r        <= err_n;
    end
  end

  // Next-state and next-output decode for the load sequence.
  always_comb begin
    state_n      = state_r;
    count_n      = count_r;
    words_n      = words_r;
    tmo_n        = tmo_r;
    rel_n        = rel_r;
    w_en_n       = 1'b0;
    addr_n       = addr_r;
    data_n       = data_r;
    program_n    = program_r;
    core_rst_n_n = core_rst_n_r;
    busy_n       = busy_r;
    done_n       = done_r;
    err_n        = err_r;
    asm_clr_s    = 1'b0;

    case (state_r)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (ld_start) begin
          state_n      = LD_HDR;
          done_n       = 1'b0;
          err_n        = LD_ERR_NONE;
          words_n      = 32'd0;
          tmo_n        = 32'd0;
          asm_clr_s    = 1'b1;
          program_n    = 1'b1;
          core_rst_n_n = 1'b0;
          busy_n       = 1'b1;
        end else begin
          state_n = state_r;
        end
      end
      LD_HDR, LD_DATA: begin
        if (fire_s) begin
          tmo_n = 32'd0;
          if (word_valid_s && (state_r == LD_HDR)) begin
            count_n = word_s;
            if (count_ok(word_s, IMEM_DEPTH)) begin
              state_n = LD_DATA;
            end else begin
              // core_rst_n stays low so a half-loaded core never runs.
              state_n   = LD_ERR;
              err_n     = LD_ERR_COUNT;
              program_n = 1'b0;
              busy_n    = 1'b0;
            end
          end else if (word_valid_s) begin
            state_n = LD_WRITE;
            w_en_n  = 1'b1;
            addr_n  = words_r[IMEM_ADDR_W-1:0];
            data_n  = word_s;
          end else begin
            state_n = state_r;
          end
        end else if ((tmo_r + 32'd1) >= 32'(TIMEOUT_CYCLES)) begin
          state_n   = LD_ERR;
          err_n     = LD_ERR_TIMEOUT;
          program_n = 1'b0;
          busy_n    = 1'b0;
        end else begin
          tmo_n = tmo_r + 32'd1;
        end
      end
      LD_WRITE: begin
        words_n = words_r + 32'd1;
        // The edge leaving WRITE counts as the first release-delay cycle.
        rel_n   = 32'd1;
        if ((words_r + 32'd1) == count_r) begin
          state_n = LD_RELEASE;
        end else begin
          state_n = LD_DATA;
        end
      end
      LD_RELEASE: begin
        if ((rel_r + 32'd1) >= 32'(RELEASE_DELAY)) begin
          state_n      = LD_DONE;
          program_n    = 1'b0;
          core_rst_n_n = 1'b1;
          busy_n       = 1'b0;
          done_n       = 1'b1;
        end else begin
          rel_n = rel_r + 32'd1;
        end
      end
      default: begin
        state_n = LD_IDLE;
      end
    endcase

    ready_n = (state_n == LD_HDR) || (state_n == LD_DATA);
  end

  assign ld_byte_ready     = ready_r;
  assign rv32_io_imem_w_en = w_en_r;
  assign rv32_io_imem_addr = addr_r;
  assign rv32_io_imem_data = data_r;
  assign rv32_io_program   = program_r;
  assign core_rst_n        = core_rst_n_r;
  assign ld_busy           = busy_r;
  assign ld_done           = done_r;
  assign ld_err            = err_r;
  assign ld_words          = words_r;

endmodule

// File: tb/tb_rv32_imem_loader.sv
// Self-checking bench for rv32_imem_loader: directed loads with a write
// scoreboard checked by a separate monitor process.
module tb_rv32_imem_loader;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_byte = 8'd0;
  logic        ld_byte_valid = 1'b0;
  logic        ld_byte_ready;
  logic        w_en;
  logic [9:0]  addr;
  logic [31:0] data;
  logic        prog_mode;
  logic        core_rst_n;
  logic        ld_busy;
  logic        ld_done;
  logic [1:0]  ld_err;
  logic [31:0] ld_words;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fire_cyc = 0;
  int last_w_cyc = 0;
  int gi = 0;
  exp_t exp_q[$];
  int gap_tab[12] = '{0, 3, 1, 5, 0, 2, 7, 0, 1, 4, 0, 6};
  logic [31:0] prog_words[3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};

  rv32_imem_loader #(
    .IMEM_DEPTH     (1024),
    .TIMEOUT_CYCLES (16),
    .RELEASE_DELAY  (2)
  ) dut (
    .rv32_io_clk       (clk),
    .rv32_io_rst_n     (rst_n),
    .ld_start          (ld_start),
    .ld_byte           (ld_byte),
    .ld_byte_valid     (ld_byte_valid),
    .ld_byte_ready     (ld_byte_ready),
    .rv32_io_imem_w_en (w_en),
    .rv32_io_imem_addr (addr),
    .rv32_io_imem_data (data),
    .rv32_io_program   (prog_mode),
    .core_rst_n        (core_rst_n),
    .ld_busy           (ld_busy),
    .ld_done           (ld_done),
    .ld_err            (ld_err),
    .ld_words          (ld_words)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (w_en === 1'b1) begin
        last_w_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(addr), 32'(e.addr));
          check("wr_data", data, e.data);
          check("wr_latency", 32'(cyc - last_fire_cyc), 32'd0);
        end
      end
    end
  endtask

  task automatic do_start();
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  task automatic idle(input int n, input bit pulse);
    ld_byte_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_start = pulse && (i == 0);
      @(posedge clk); #1;
    end
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic acc;
    ld_byte = b;
    ld_byte_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ld_byte_ready;
      @(posedge clk); #1;
      n++;
    end
    ld_byte_valid = 1'b0;
    if (acc) last_fire_cyc = cyc;
    else check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit push, input logic [9:0] a,
                           input bit gapped);
    for (int i = 0; i < 4; i++) begin
      if (gapped) begin
        idle(gap_tab[gi % 12], i == 1);
        gi++;
      end
      if (push && i == 3) exp_q.push_back({a, w});
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic run_program(input bit gapped);
    do_start();
    send_word(32'd3, 1'b0, 10'd0, gapped);
    for (int i = 0; i < 3; i++) send_word(prog_words[i], 1'b1, 10'(i), gapped);
  endtask

  task automatic wait_release(input logic [31:0] exp_words);
    int n;
    n = 0;
    @(negedge clk);
    while (core_rst_n !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("release_delay", 32'(cyc - last_w_cyc), 32'd2);
    check("done_flag", 32'(ld_done), 32'd1);
    check("words_count", ld_words, exp_words);
    check("program_off", 32'(prog_mode), 32'd0);
    check("busy_off", 32'(ld_busy), 32'd0);
    check("err_none", 32'(ld_err), 32'd0);
  endtask

  task automatic check_error(input logic [1:0] code, input string tag);
    check({tag, "_err"}, 32'(ld_err), 32'(code));
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_program"}, 32'(prog_mode), 32'd0);
    check({tag, "_busy"}, 32'(ld_busy), 32'd0);
    check({tag, "_ready"}, 32'(ld_byte_ready), 32'd0);
    check({tag, "_done"}, 32'(ld_done), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd1);
    check({tag, "_program"}, 32'(prog_mode), 32'd0);
    check({tag, "_w_en"}, 32'(w_en), 32'd0);
    check({tag, "_done"}, 32'(ld_done), 32'd0);
    check({tag, "_err"}, 32'(ld_err), 32'd0);
    check({tag, "_ready"}, 32'(ld_byte_ready), 32'd0);
    check({tag, "_busy"}, 32'(ld_busy), 32'd0);
    check({tag, "_words"}, ld_words, 32'd0);
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state("post_rst");

    // Gap-free three-word program.
    run_program(1'b0);
    wait_release(32'd3);

    // Zero word count.
    do_start();
    check("start_program", 32'(prog_mode), 32'd1);
    check("start_core_rst_n", 32'(core_rst_n), 32'd0);
    check("start_clears_done", 32'(ld_done), 32'd0);
    send_word(32'd0, 1'b0, 10'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_error(2'd1, "cnt0");

    // Count one past the imem depth.
    do_start();
    send_word(32'h00000401, 1'b0, 10'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_error(2'd1, "cnt401");

    // Timeout after one written word and a partial second word.
    do_start();
    send_word(32'd2, 1'b0, 10'd0, 1'b0);
    send_word(32'hDEADBEEF, 1'b1, 10'd0, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    n = 0;
    @(negedge clk);
    while (ld_err !== 2'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_idle_cycles", 32'(cyc - last_fire_cyc), 32'd16);
    check_error(2'd2, "tmo");
    check("tmo_words", ld_words, 32'd1);

    // Same program with valid gaps and ignored start pulses.
    run_program(1'b1);
    wait_release(32'd3);

    // Asynchronous reset in the middle of the second word.
    do_start();
    send_word(32'd3, 1'b0, 10'd0, 1'b0);
    send_word(prog_words[0], 1'b1, 10'd0, 1'b0);
    send_byte(8'h13);
    send_byte(8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One-word load after the reset.
    do_start();
    send_word(32'd1, 1'b0, 10'd0, 1'b0);
    send_word(32'h00000013, 1'b1, 10'd0, 1'b0);
    wait_release(32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_imem_loader.md
Name: rv32_imem_loader

Overview:
- Hardware program loader: the transmitting end of the core's instruction-memory programming port (`imem_w_en` / `imem_addr` / `imem_data` / `program`).
- Accepts a host byte stream, assembles 32-bit little-endian words and writes them to consecutive imem addresses. Holds the core in reset and in program mode while loading, then releases it.
- Sits between a host link (UART/JTAG byte FIFO) and `rv32_core`.

Parameters:
- IMEM_DEPTH, 1024, number of 32-bit instruction words; the header count must not exceed it.
- TIMEOUT_CYCLES, 65535, maximum idle cycles between bytes during a load before aborting.
- RELEASE_DELAY, 2, cycles between the last imem write and deassertion of `core_rst_n`.

Ports:
- rv32_io_clk  in  1  clock
- rv32_io_rst_n  in  1  asynchronous reset, active low
- ld_start  in  1  single-cycle pulse; begins a load; ignored unless in IDLE, DONE or ERR
- ld_byte  in  8  stream data byte
- ld_byte_valid  in  1  byte present
- ld_byte_ready  out  1  loader accepts `ld_byte` this cycle (transfer when valid && ready)
- rv32_io_imem_w_en  out  1  imem write strobe
- rv32_io_imem_addr  out  rv32_imem_addr_t  write word address
- rv32_io_imem_data  out  rv32_instr_t  write data
- rv32_io_program  out  1  core program mode
- core_rst_n  out  1  core reset, active low
- ld_busy  out  1  load in progress
- ld_done  out  1  last load completed; sticky until next `ld_start`
- ld_err  out  2  0 none, 1 bad count (0 or >IMEM_DEPTH), 2 timeout; sticky until next `ld_start`
- ld_words  out  32  number of words written in the current/last load

Behaviour:
- Reset values:
  - all outputs 0;
  - `core_rst_n`=1 (core runs);
  - FSM in IDLE.
- States: IDLE, HDR, DATA, WRITE, RELEASE, DONE, ERR.
- IDLE / DONE / ERR:
  - `ld_byte_ready`=0.
  - `ld_start` -> HDR. Same edge: clear `ld_done`, `ld_err`, `ld_words`, byte index, timeout counter; assert `program`=1, `core_rst_n`=0, `busy`=1.
- HDR:
  - `ready`=1; accept 4 bytes, LSB first, into `count`.
  - On the 4th byte: count==0 or count>IMEM_DEPTH -> ERR with code 1; else -> DATA.
- DATA:
  - `ready`=1; accept 4 bytes LSB first into the word shift register.
  - On the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - `ready`=0;
  - `imem_w_en`=1, `imem_addr`=`ld_words`, `imem_data`=assembled word.
  - Next edge: `ld_words`++; if `ld_words`+1==count -> RELEASE, else -> DATA.
- Write latency: `imem_w_en` is high in the cycle after the 4th byte handshake. Max throughput is one word per 5 cycles.
- `imem_addr` and `imem_data` are held stable when `w_en`=0, for debug only.
- RELEASE: wait RELEASE_DELAY cycles; then `program`=0, `core_rst_n`=1, `busy`=0, `ld_done`=1 -> DONE.
- ERR:
  - `program`=0, `busy`=0;
  - `core_rst_n` stays 0, so a partially loaded core never runs;
  - only `ld_start` or `rv32_io_rst_n` exits.
- Timeout:
  - Counter runs in HDR/DATA and clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES -> ERR with code 2.
- Bytes presented while `ready`=0 are not consumed; the producer holds them.
- `ld_start` while busy is ignored.
- Asynchronous reset mid-load:
  - immediate return to reset values, including `core_rst_n`=1;
  - already written imem words remain.
- Address width: `imem_addr` is the truncated `ld_words`; the count check guarantees no wrap.

Decomposition:
- Shared package `rv32_defines`: `rv32_imem_addr_t`, `rv32_instr_t`, `ld_state_t` enum, `ld_err_t` enum (`LD_ERR_NONE`, `LD_ERR_COUNT`, `LD_ERR_TIMEOUT`).
- One natural sub-module: `rv32_byte_assembler`. It takes the byte handshake in, keeps a 2-bit index, and outputs a 32-bit little-endian word with a `word_valid` pulse; it is reused for header and data.
- FSM, counters and timeout live in the top.

Test Plan:
- Reset -> `core_rst_n`=1, `program`=0, `w_en`=0, `done`=0, `err`=0, `ready`=0.
- `ld_start`; header 03 00 00 00; words 0x00500093, 0x00A00113, 0x002081B3, sent as bytes LSB first with valid held high -> three `w_en` pulses at addr 0,1,2 with exact data, each one cycle after the 4th byte.
  - Expected on completion: `ld_words`=3, `core_rst_n` rises 2 cycles after the last write, `done`=1.
- Header 00 00 00 00 -> `err`=1, no `w_en`, `core_rst_n` stays 0. Header 0x401 with IMEM_DEPTH=1024 -> `err`=1.
- Count=2, send 6 data bytes then stop, with TIMEOUT_CYCLES=16 -> one write at addr 0, `err`=2 after 16 idle cycles, `core_rst_n`=0.
- Random valid gaps and `ld_start` pulses during HDR/DATA -> pulses ignored; data and addresses identical to the gap-free run.
- Assert `rv32_io_rst_n`=0 during the second word -> outputs return to reset values asynchronously. A new load of 1 word afterwards -> addr 0 written, `done`=1.
